// File: rtl/dual_rail_sweep_pkg.sv
// Shared constants and state encoding for the dual-rail truth-table sweeper.
package dual_rail_sweep_pkg;

   localparam int N_VARS = 4;
   localparam int N_VEC  = 16;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      SETTLE = ST_SETTLE,
      SAMPLE = ST_SAMPLE,
      DONE   = ST_DONE
   } state_t;

endpackage

// File: rtl/dual_rail_sweep_drv.sv
// Vector index register driving four complementary rail pairs (A = MSB, D = LSB).
module dual_rail_drv
   import dual_rail_sweep_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   output logic [N_VARS-1:0] idx,
   output logic              a,
   output logic              not_a,
   output logic              b,
   output logic              not_b,
   output logic              c,
   output logic              not_c,
   output logic              d,
   output logic              not_d
);

   logic [N_VARS-1:0] idx_r;

   // Index register: cleared on an accepted start, advanced after each sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r <= 4'd0;
      end else if (clr) begin
         idx_r <= 4'd0;
      end else if (inc) begin
         idx_r <= idx_r + 4'd1;
      end else begin
         idx_r <= idx_r;
      end
   end

   // Complement rails come straight off the same flops, so they stay exact inverses even in reset.
   assign idx   = idx_r;
   assign a     = idx_r[3];
   assign not_a = ~idx_r[3];
   assign b     = idx_r[2];
   assign not_b = ~idx_r[2];
   assign c     = idx_r[1];
   assign not_c = ~idx_r[1];
   assign d     = idx_r[0];
   assign not_d = ~idx_r[0];

endmodule

// File: rtl/dual_rail_sweep.sv
// Sweeps all 16 dual-rail input vectors and captures f_in into a truth table.
// Optional golden-table compare is enabled by defining DUAL_RAIL_SWEEP_CHECK_EN.
module dual_rail_sweep
   import dual_rail_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             f_in,
   output logic             a,
   output logic             not_a,
   output logic             b,
   output logic             not_b,
   output logic             c,
   output logic             not_c,
   output logic             d,
   output logic             not_d,
   output logic             busy,
   output logic             done,
   output logic [N_VEC-1:0] tt,
   output logic [4:0]       ones_cnt
`ifdef DUAL_RAIL_SWEEP_CHECK_EN
   ,
   input  logic [N_VEC-1:0] expected_tt,
   output logic             mismatch
`endif
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t            state_r;
   state_t            state_s;
   logic [3:0]        settle_cnt_r;
   logic [N_VARS-1:0] idx_s;
   logic              accept_s;
   logic              sample_s;
   logic              last_s;
   logic [N_VEC-1:0]  tt_next_s;

   dual_rail_drv u_drv (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept_s),
      .inc   (sample_s & ~last_s),
      .idx   (idx_s),
      .a     (a),
      .not_a (not_a),
      .b     (b),
      .not_b (not_b),
      .c     (c),
      .not_c (not_c),
      .d     (d),
      .not_d (not_d)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and control strobes; start is only honoured from IDLE or DONE.
   always_comb begin
      state_s   = state_r;
      accept_s  = 1'b0;
      sample_s  = 1'b0;
      last_s    = 1'b0;
      tt_next_s = tt;
      tt_next_s[idx_s] = f_in;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               accept_s = 1'b1;
               state_s  = SETTLE;
            end else begin
               state_s  = state_r;
            end
         end
         SETTLE: begin
            if (settle_cnt_r == SETTLE_LAST) begin
               state_s = SAMPLE;
            end else begin
               state_s = SETTLE;
            end
         end
         SAMPLE: begin
            sample_s = 1'b1;
            if (idx_s == 4'd15) begin
               last_s  = 1'b1;
               state_s = DONE;
            end else begin
               state_s = SETTLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Settle counter, table capture, minterm count and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt_r <= 4'd0;
         tt           <= 16'd0;
         ones_cnt     <= 5'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else if (accept_s) begin
         settle_cnt_r <= 4'd0;
         tt           <= 16'd0;
         ones_cnt     <= 5'd0;
         busy         <= 1'b1;
         done         <= 1'b0;
      end else if (sample_s) begin
         settle_cnt_r <= 4'd0;
         tt           <= tt_next_s;
         ones_cnt     <= ones_cnt + {4'd0, f_in};
         busy         <= ~last_s;
         done         <= last_s;
      end else if (state_r == SETTLE) begin
         settle_cnt_r <= settle_cnt_r + 4'd1;
      end else begin
         settle_cnt_r <= settle_cnt_r;
      end
   end

`ifdef DUAL_RAIL_SWEEP_CHECK_EN
   // Golden compare uses the final table including the bit captured on the last sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch <= 1'b0;
      end else if (accept_s) begin
         mismatch <= 1'b0;
      end else if (sample_s && last_s) begin
         mismatch <= (tt_next_s != expected_tt);
      end else begin
         mismatch <= mismatch;
      end
   end
`endif

endmodule

// File: tb/tb_dual_rail_sweep.sv
// Self-checking bench for dual_rail_sweep: table-driven functions, random tables, corner sequences.
module tb_dual_rail_sweep;

   localparam int S        = 2;
   localparam int VEC_CLKS = S + 1;
   localparam int DONE_LAT = 16 * VEC_CLKS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        f_in;
   logic        a, not_a, b, not_b, c, not_c, d, not_d;
   logic        busy, done;
   logic [15:0] tt;
   logic [4:0]  ones_cnt;
`ifdef DUAL_RAIL_SWEEP_CHECK_EN
   logic [15:0] expected_tt = 16'd0;
   logic        mismatch;
`endif

   int          mode = 0;
   logic [15:0] rand_tt = 16'd0;
   int          chk_cnt = 0;
   int          pass_cnt = 0;

   typedef struct {
      int          mode;
      logic [15:0] tt;
      logic [4:0]  ones;
      int          extra;
      string       name;
   } vec_t;

   vec_t tbl[5];

   always #5 clk = ~clk;

   dual_rail_sweep #(.SETTLE_CYCLES(S)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .f_in     (f_in),
      .a        (a),
      .not_a    (not_a),
      .b        (b),
      .not_b    (not_b),
      .c        (c),
      .not_c    (not_c),
      .d        (d),
      .not_d    (not_d),
      .busy     (busy),
      .done     (done),
      .tt       (tt),
      .ones_cnt (ones_cnt)
`ifdef DUAL_RAIL_SWEEP_CHECK_EN
      ,
      .expected_tt (expected_tt),
      .mismatch    (mismatch)
`endif
   );

   // Function under evaluation, computed from the true rails.
   always_comb begin
      f_in = 1'b0;
      case (mode)
         0: f_in = a & b & c & d;
         1: f_in = a ^ b ^ c ^ d;
         2: f_in = 1'b0;
         3: f_in = 1'b1;
         4: f_in = a | b;
         5: f_in = rand_tt[{a, b, c, d}];
         default: f_in = 1'b0;
      endcase
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // One sweep; checks rails per cycle, busy, done latency and the final table.
   task automatic run_sweep(input logic [15:0] etv, input logic [4:0] eo, input int extra_at,
                            input string nm);
      int lat;
      bit rail_ok;
      bit busy_ok;
      lat = -1;
      rail_ok = 1'b1;
      busy_ok = 1'b1;
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      for (int n = 0; n < 100 && lat < 0; n++) begin
         if ({not_a, not_b, not_c, not_d} !== ~{a, b, c, d}) rail_ok = 1'b0;
         if (done) begin
            lat = n;
         end else begin
            if ({a, b, c, d} !== 4'(n / VEC_CLKS)) rail_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (n == extra_at) ? 1'b1 : 1'b0;
            @(posedge clk) #1;
         end
      end
      start = 1'b0;
      check({nm, " rails"}, 32'(rail_ok), 32'd1);
      check({nm, " busy_during"}, 32'(busy_ok), 32'd1);
      check({nm, " done_latency"}, 32'(lat), 32'(DONE_LAT));
      check({nm, " tt"}, 32'(tt), 32'(etv));
      check({nm, " ones_cnt"}, 32'(ones_cnt), 32'(eo));
      check({nm, " busy_after"}, 32'(busy), 32'd0);
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, " busy"}, 32'(busy), 32'd0);
      check({nm, " done"}, 32'(done), 32'd0);
      check({nm, " tt"}, 32'(tt), 32'd0);
      check({nm, " ones"}, 32'(ones_cnt), 32'd0);
      check({nm, " rails"}, 32'({a, b, c, d, not_a, not_b, not_c, not_d}), 32'h0F);
   endtask

   initial begin
      logic [15:0] rt;
      logic [4:0]  ro;
      tbl[0] = '{0, 16'h8000, 5'd1,  -1, "and4"};
      tbl[1] = '{1, 16'h6996, 5'd8,  10, "xor4_extra_start"};
      tbl[2] = '{2, 16'h0000, 5'd0,  -1, "zero"};
      tbl[3] = '{3, 16'hFFFF, 5'd16, -1, "one"};
      tbl[4] = '{4, 16'hFFF0, 5'd12, -1, "a_or_b"};

      #3 check_reset_vals("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("idle_no_done", 32'(done), 32'd0);

      for (int i = 0; i < 5; i++) begin
         mode = tbl[i].mode;
         run_sweep(tbl[i].tt, tbl[i].ones, tbl[i].extra, tbl[i].name);
         if (i == 0) begin
            mode = 3;
            repeat (5) @(posedge clk);
            #1;
            check("hold tt", 32'(tt), 32'h8000);
            check("hold done", 32'(done), 32'd1);
            check("hold ones", 32'(ones_cnt), 32'd1);
            check("hold rails", 32'({a, b, c, d}), 32'hF);
         end
      end

      // Random tables with a stray start at a random point of the sweep.
      for (int r = 0; r < 4; r++) begin
         rand_tt = 16'($urandom);
         mode = 5;
         rt = rand_tt;
         ro = 5'd0;
         for (int k = 0; k < 16; k++) ro = ro + {4'd0, rt[k]};
         run_sweep(rt, ro, int'($urandom_range(1, 40)), "random");
      end

      // Reset in the middle of a sweep.
      mode = 1;
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_vals("midsweep_reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1 check("no_done_after_reset", 32'(done), 32'd0);
      run_sweep(16'h6996, 5'd8, -1, "after_reset");

`ifdef DUAL_RAIL_SWEEP_CHECK_EN
      mode = 4;
      expected_tt = 16'hFFF0;
      run_sweep(16'hFFF0, 5'd12, -1, "chk_match");
      check("mismatch0", 32'(mismatch), 32'd0);
      expected_tt = 16'hFFF1;
      run_sweep(16'hFFF0, 5'd12, -1, "chk_diff");
      check("mismatch1", 32'(mismatch), 32'd1);
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      check("mismatch_cleared", 32'(mismatch), 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
